lsu_stage: RTL and testbench

Load/store stage of the single-issue RV64 core. It sits directly downstream of the execute unit and consumes its ALU result (address) and rs2 data. It issues at most one aligned 64-bit request on the data-memory request/response bus and returns an aligned, sign- or zero-extended writeback value. Non-memory instructions pass through with one cycle of latency, so every instruction flows through the stage.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_stage.sv | 113 +++++++++++
 tb/tb_lsu_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, encodings and helpers for the load/store stage.
package lsu_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Context of the in-flight memory access, kept for response formatting.
  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [2:0] off;
    logic [4:0] rd;
  } lsu_ctx_t;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed lane of a read doubleword and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] sh;
  logic            sx;

  assign sh = rdata >> {off, 3'b000};
  assign sx = ~funct3[2];

  always_comb begin
    data = sh;
    case (funct3[1:0])
      2'b00:   data = {{(XLEN-8){sx & sh[7]}}, sh[7:0]};
      2'b01:   data = {{(XLEN-16){sx & sh[15]}}, sh[15:0]};
      2'b10:   data = {{(XLEN-32){sx & sh[31]}}, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: one aligned doubleword bus request per memory op,
// one-cycle pass-through for everything else.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_err
);

  lsu_state_e      state;
  lsu_ctx_t        ctx;
  logic            accept, in_is_ld, in_is_st, in_bad;
  logic [XLEN-1:0] ld_data;

  assign in_ready = (state == S_IDLE) | ((state == S_RESP) & out_ready);
  assign accept   = in_valid & in_ready;
  assign in_is_ld = (in_op == OP_LOAD);
  assign in_is_st = (in_op == OP_STORE);
  assign in_bad   = (in_is_ld & (in_funct3 == 3'b111)) | (in_is_st & in_funct3[2])
                  | misaligned(in_funct3[1:0], in_addr[2:0]);

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (mem_rdata),
    .off    (ctx.off),
    .funct3 (ctx.funct3),
    .data   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ctx       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      ctx    <= '{is_store: in_is_st, funct3: in_funct3, off: in_addr[2:0], rd: in_rd};
      out_rd <= in_rd;
      // Non-memory ops and faulting accesses never touch the bus.
      if (!(in_is_ld | in_is_st) || in_bad) begin
        state     <= S_RESP;
        out_valid <= 1'b1;
        out_data  <= in_addr;
        out_err   <= in_is_ld | in_is_st;
      end else begin
        state     <= S_REQ;
        out_valid <= 1'b0;
        out_err   <= 1'b0;
        mem_req   <= 1'b1;
        mem_we    <= in_is_st;
        mem_addr  <= {in_addr[XLEN-1:3], 3'b000};
        mem_wdata <= in_is_st ? (in_wdata << {in_addr[2:0], 3'b000}) : '0;
        mem_wmask <= in_is_st ? (size_mask(in_funct3[1:0]) << in_addr[2:0]) : 8'h00;
      end
    end else begin
      case (state)
        S_REQ: if (mem_gnt) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_wmask <= 8'h00;
          if (ctx.is_store) begin
            state     <= S_RESP;
            out_valid <= 1'b1;
            out_data  <= '0;
            out_err   <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: if (mem_rvalid) begin
          state     <= S_RESP;
          out_valid <= 1'b1;
          out_data  <= ld_data;
          out_err   <= 1'b0;
        end
        S_RESP: if (out_ready) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage with a writeback scoreboard.
module tb_lsu_stage;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic [63:0] in_addr = '0, in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;

  lsu_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Writeback handshakes are scored mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", {63'b0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wb_data", out_data, mon_e.data);
        chk("wb_rd", {59'b0, out_rd}, {59'b0, mon_e.rd});
        chk("wb_err", {63'b0, out_err}, {63'b0, mon_e.err});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] rd);
    chk("in_ready", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1; in_op = op; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                          input logic [4:0] rd, input logic [7:0] mask, input logic [63:0] ewd);
    sb.push_back('{64'd0, rd, 1'b0});
    issue(OP_STORE, f3, a, wd, rd);
    chk("st_req", {63'b0, mem_req}, 64'd1);
    chk("st_we", {63'b0, mem_we}, 64'd1);
    chk("st_addr", mem_addr, {a[63:3], 3'b000});
    chk("st_mask", {56'b0, mem_wmask}, {56'b0, mask});
    chk("st_wdata", mem_wdata, ewd);
    chk("st_nvalid", {63'b0, out_valid}, 64'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("st_valid", {63'b0, out_valid}, 64'd1);
    chk("st_req_drop", {63'b0, mem_req}, 64'd0);
    step();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [63:0] a, input logic [4:0] rd,
                         input logic [63:0] rdata, input logic [63:0] exp);
    sb.push_back('{exp, rd, 1'b0});
    issue(OP_LOAD, f3, a, 64'd0, rd);
    chk("ld_req", {63'b0, mem_req}, 64'd1);
    chk("ld_we", {63'b0, mem_we}, 64'd0);
    chk("ld_mask", {56'b0, mem_wmask}, 64'd0);
    chk("ld_addr", mem_addr, {a[63:3], 3'b000});
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("ld_wait_req", {63'b0, mem_req}, 64'd0);
    chk("ld_wait_nvalid", {63'b0, out_valid}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0;
    chk("ld_valid", {63'b0, out_valid}, 64'd1);
    step();
  endtask

  task automatic do_imm(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] a,
                        input logic [4:0] rd, input logic err);
    sb.push_back('{a, rd, err});
    issue(op, f3, a, 64'hFFFF_FFFF_FFFF_FFFF, rd);
    chk("imm_noreq", {63'b0, mem_req}, 64'd0);
    chk("imm_valid", {63'b0, out_valid}, 64'd1);
    chk("imm_err", {63'b0, out_err}, {63'b0, err});
    chk("imm_data", out_data, a);
    step();
  endtask

  logic [63:0] snap_addr, snap_wdata, snap_data;
  logic [7:0]  snap_mask;
  localparam logic [63:0] RD8 = 64'h8122_33F4_5566_7788;

  initial begin
    #2;
    chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wmask", {56'b0, mem_wmask}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_rd", {59'b0, out_rd}, 64'd0);
    chk("rst_out_err", {63'b0, out_err}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    do_store(F3_SB, 64'h8000_0003, 64'h0000_0000_0000_00AB, 5'd1, 8'h08, 64'h0000_0000_AB00_0000);
    do_store(F3_SH, 64'h8000_0006, 64'h0000_0000_0000_1234, 5'd2, 8'hC0, 64'h1234_0000_0000_0000);
    do_store(F3_SW, 64'h8000_0004, 64'hFFFF_FFFF_A5A5_5A5A, 5'd3, 8'hF0, 64'hA5A5_5A5A_0000_0000);

    do_load(F3_LH,  64'h8000_0006, 5'd4, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    do_load(F3_LHU, 64'h8000_0006, 5'd5, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    do_load(F3_LB,  64'h8000_0004, 5'd6, RD8, 64'hFFFF_FFFF_FFFF_FFF4);
    do_load(F3_LBU, 64'h8000_0000, 5'd7, RD8, 64'h0000_0000_0000_0088);
    do_load(F3_LW,  64'h8000_0004, 5'd8, RD8, 64'hFFFF_FFFF_8122_33F4);
    do_load(F3_LWU, 64'h8000_0004, 5'd9, RD8, 64'h0000_0000_8122_33F4);

    do_imm(OP_LOAD,  F3_LW, 64'h8000_0002, 5'd10, 1'b1);
    do_imm(OP_LOAD,  F3_LH, 64'h8000_0001, 5'd11, 1'b1);
    do_imm(OP_STORE, F3_SD, 64'h8000_0004, 5'd12, 1'b1);
    do_imm(OP_LOAD,  3'b111, 64'h8000_0000, 5'd13, 1'b1);
    do_imm(OP_STORE, 3'b100, 64'h8000_0000, 5'd14, 1'b1);
    do_imm(OP_PASS,  3'b000, 64'h1234_5678_9ABC_DEF1, 5'd15, 1'b0);

    // Bus stall on grant, then writeback stall, then back-to-back pass-throughs.
    out_ready = 1'b0;
    sb.push_back('{64'd0, 5'd20, 1'b0});
    issue(OP_STORE, F3_SD, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 5'd20);
    snap_addr = mem_addr; snap_wdata = mem_wdata; snap_mask = mem_wmask;
    chk("gd_wdata", snap_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gd_req_hold", {63'b0, mem_req}, 64'd1);
      chk("gd_addr_hold", mem_addr, snap_addr);
      chk("gd_wdata_hold", mem_wdata, snap_wdata);
      chk("gd_mask_hold", {56'b0, mem_wmask}, {56'b0, snap_mask});
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("bp_valid", {63'b0, out_valid}, 64'd1);
    snap_data = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", {63'b0, out_valid}, 64'd1);
      chk("bp_data_hold", out_data, snap_data);
      chk("bp_rd_hold", {59'b0, out_rd}, 64'd20);
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    end
    for (int k = 0; k < 4; k++)
      sb.push_back('{64'h0000_1000 + 64'(k), 5'(21 + k), 1'b0});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_op = (k == 2) ? OP_RSVD : OP_PASS;
      in_addr = 64'h0000_1000 + 64'(k);
      in_rd = 5'(21 + k);
      step();
      chk("b2b_valid", {63'b0, out_valid}, 64'd1);
      chk("b2b_data", out_data, 64'h0000_1000 + 64'(k));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_idle", {63'b0, out_valid}, 64'd0);

    // Reset during WAIT drops the load; a late rvalid must not produce writeback.
    issue(OP_LOAD, F3_LW, 64'h8000_0020, 64'd0, 5'd30);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    step();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rvalid", {63'b0, out_valid}, 64'd0);
      step();
    end

    do_load(F3_LD, 64'h8000_0008, 5'd17, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
